seq_signed_divider: RTL and testbench

//   Iterative signed integer divider. It is the inverse-operation companion to the

---
 rtl/seq_signed_divider.sv | 112 +++++++++++
 tb/tb_seq_signed_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - iterative radix-2 restoring signed divider with start/busy/done handshake
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             sign_r;
    logic             zero;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH+1:0] trial;

    // dvd shifts dividend magnitude bits out of its top and quotient bits in at the bottom
    always_comb begin
        mag_a = dividend[WIDTH-1] ? -dividend : dividend;
        mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
        trial = {prem, dvd[WIDTH-1]} - {2'b00, dvs};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            prem        <= '0;
            dvd         <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r <= dividend[WIDTH-1];
                        prem   <= '0;
                        dvs    <= mag_b;
                        count  <= CW'(WIDTH - 1);
                        // a zero divisor keeps the raw dividend so it can be returned as the remainder
                        if (divisor == '0) begin
                            zero  <= 1'b1;
                            dvd   <= dividend;
                            state <= FIX;
                        end else begin
                            zero  <= 1'b0;
                            dvd   <= mag_a;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH+1]) begin
                        prem <= trial[WIDTH:0];
                    end else begin
                        prem <= {prem[WIDTH-1:0], dvd[WIDTH-1]};
                    end
                    dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH+1]};
                    count <= count - CW'(1);
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero) begin
                        quotient  <= '1;
                        remainder <= dvd;
                    end else begin
                        quotient  <= sign_q ? -dvd : dvd;
                        remainder <= sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                    end
                    div_by_zero <= zero;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - randomized self-checking bench for seq_signed_divider
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cur_q, cur_r, pend_q, pend_r;
    logic        cur_dz, pend_dz, pend_valid;

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic truncated back to 32 bits
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        longint la, lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else begin
            q = 32'(la / lb); r = 32'(la % lb); dz = 1'b0;
        end
    endfunction

    // Outputs must equal the last completed result on every cycle; a done pulse publishes the pending one
    always @(negedge clk) begin
        if (done && pend_valid) begin
            cur_q = pend_q; cur_r = pend_r; cur_dz = pend_dz;
            pend_valid = 1'b0;
        end
        check("mon_quotient", quotient, cur_q);
        check("mon_remainder", remainder, cur_r);
        check("mon_div_by_zero", {31'd0, div_by_zero}, {31'd0, cur_dz});
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input bit disturb);
        int cyc;
        bit got;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1; en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model(a, b, pend_q, pend_r, pend_dz);
        pend_valid = 1'b1;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (disturb && cyc == 3) begin
                dividend = 32'd1; divisor = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            en = !(disturb && cyc >= 10 && cyc < 15);
            @(posedge clk);
            cyc++;
            #1;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        en = 1'b1;
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", cyc, exp_lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_out(input logic [31:0] q, input logic [31:0] r, input logic dz);
        check("lit_quotient", quotient, q);
        check("lit_remainder", remainder, r);
        check("lit_div_by_zero", {31'd0, div_by_zero}, {31'd0, dz});
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd0;
            3: v = 32'($urandom_range(0, 20));
            4: v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] mq, mr, a, b;
        logic        mdz;
        longint      lq, lr, la, lb;

        rst = 1'b0; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        cur_q = '0; cur_r = '0; cur_dz = 1'b0; pend_valid = 1'b0;
        pend_q = '0; pend_r = '0; pend_dz = 1'b0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        model(32'd100, 32'd7, mq, mr, mdz);
        check("model_100_7_q", mq, 32'd14);
        check("model_100_7_r", mr, 32'd2);
        model(-32'd100, -32'd7, mq, mr, mdz);
        check("model_n100_n7_q", mq, 32'd14);
        check("model_n100_n7_r", mr, 32'hFFFF_FFFE);
        model(32'h8000_0000, 32'hFFFF_FFFF, mq, mr, mdz);
        check("model_min_q", mq, 32'h8000_0000);
        check("model_min_r", mr, 32'd0);

        run_div(32'd100, 32'd7, 33, 1'b0);
        check_out(32'd14, 32'd2, 1'b0);
        run_div(-32'd100, 32'd7, 33, 1'b0);
        check_out(-32'd14, -32'd2, 1'b0);
        run_div(32'd100, -32'd7, 33, 1'b0);
        check_out(-32'd14, 32'd2, 1'b0);
        run_div(-32'd100, -32'd7, 33, 1'b0);
        check_out(32'd14, -32'd2, 1'b0);
        run_div(32'h1234_5678, 32'd0, 1, 1'b0);
        check_out(32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_div(32'd9, 32'd3, 33, 1'b0);
        check_out(32'd3, 32'd0, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0);
        check_out(32'h8000_0000, 32'd0, 1'b0);
        run_div(32'd5, 32'd9, 33, 1'b0);
        check_out(32'd0, 32'd5, 1'b0);
        run_div(32'd1000, 32'd10, 38, 1'b1);
        check_out(32'd100, 32'd0, 1'b0);

        // Asynchronous reset in the middle of a calculation
        @(negedge clk);
        dividend = 32'd77; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        cur_q = '0; cur_r = '0; cur_dz = 1'b0; pend_valid = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_div(32'd50, 32'd5, 33, 1'b0);
        check_out(32'd10, 32'd0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            a = rnd_op();
            b = rnd_op();
            run_div(a, b, (b == 32'd0) ? 1 : 33, 1'b0);
            if (b != 32'd0) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                lq = longint'($signed(quotient));
                lr = longint'($signed(remainder));
                check("invariant_sum", 32'(lq * lb + lr), a);
                check("invariant_rem_mag",
                      {31'd0, ((lr < 0 ? -lr : lr) < (lb < 0 ? -lb : lb))}, 32'd1);
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
